socetlib_fifo_thresh: RTL

//  Next-generation synchronous FIFO for the UART/AHB peripheral datapaths, parametrised in width and depth.

---
 rtl/socetlib_fifo_pkg.sv | 18 +
 rtl/socetlib_fifo_ptr.sv | 19 +
 rtl/socetlib_fifo_thresh.sv | 132 +++++++++++++
 3 files changed

// File: rtl/socetlib_fifo_pkg.sv
// Shared types and helpers for the socetlib threshold FIFO.
package socetlib_fifo_pkg;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overrun;
    logic underrun;
  } fifo_status_t;

endpackage

// File: rtl/socetlib_fifo_ptr.sv
// Wrap-bit pointer counter: ADDR_W address bits plus one MSB wrap bit.
module socetlib_fifo_ptr #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W:0]   ptr
);

  // Natural wrap modulo 2*DEPTH keeps full and empty distinguishable.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)      ptr <= '0;
    else if (clr)   ptr <= '0;
    else if (inc)   ptr <= ptr + (ADDR_W + 1)'(1);
  end

endmodule

// File: rtl/socetlib_fifo_thresh.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/empty thresholds
// and sticky overrun/underrun flags. Define SOCETLIB_FIFO_PEAK_EN to build the high-water mark.
module socetlib_fifo_thresh
  import socetlib_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              clear,
  input  logic              WEN,
  input  logic [DATA_W-1:0] wdata,
  input  logic              REN,
  output logic [DATA_W-1:0] rdata,
  input  logic [CNT_W-1:0]  af_thresh,
  input  logic [CNT_W-1:0]  ae_thresh,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overrun,
  output logic              underrun,
  output logic [CNT_W-1:0]  peak
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("socetlib_fifo_thresh: DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("socetlib_fifo_thresh: DATA_W must be >= 1");
  end

  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               do_write;
  logic               do_read;
  logic               overrun_q;
  logic               underrun_q;
  fifo_status_t       st;

  // A write at full still lands when a read frees the head slot in the same cycle.
  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    if (!clear) begin
      do_write = WEN && (!st.full || REN);
      do_read  = REN && !st.empty;
    end
  end

  socetlib_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (clear),
    .inc  (do_write),
    .ptr  (wr_ptr)
  );

  socetlib_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (clear),
    .inc  (do_read),
    .ptr  (rd_ptr)
  );

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[ADDR_W-1:0]];
  assign count = CNT_W'(wr_ptr - rd_ptr);

  // Sticky error flags, cleared only by reset or clear.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (clear) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (WEN && st.full && !REN) overrun_q  <= 1'b1;
      if (REN && st.empty)        underrun_q <= 1'b1;
    end
  end

  always_comb begin
    st              = '0;
    st.full         = (count == CNT_W'(DEPTH));
    st.empty        = (count == '0);
    st.almost_full  = (count >= af_thresh);
    st.almost_empty = (count <= ae_thresh);
    st.overrun      = overrun_q;
    st.underrun     = underrun_q;
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overrun      = st.overrun;
  assign underrun     = st.underrun;

`ifdef SOCETLIB_FIFO_PEAK_EN
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] peak_q;

  always_comb begin
    count_next = count + CNT_W'(do_write) - CNT_W'(do_read);
  end

  // High-water mark of occupancy since reset or clear.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)                    peak_q <= '0;
    else if (clear)               peak_q <= '0;
    else if (count_next > peak_q) peak_q <= count_next;
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule
